mc_ctrl: RTL
============

# mc_ctrl

Multi-cycle control FSM that consumes the 5-bit instruction command code produced by the op/func decoder and sequences the datapath through FETCH, DECODE, EXEC, MEM and WB. It sits directly downstream of the decoder. It drives every datapath write strobe and mux select, waits on a memory-ready handshake, and counts retired instructions.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- command  in  5  decoder code: 0 nop, 1 add, 2 sub, 3 ori, 4 lw, 5 sw, 6 beq, 7 jal, 8 jr, 9 lui; 10–31 treated as nop.
- alu_zero  in  1  ALU equality result, used by beq in EXEC.
- mem_ready  in  1  data memory completes the current access this cycle.
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
- ir_we  out  1  load instruction register.
- pc_we  out  1  load PC.
- pc_src  out  2  0 pc+4, 1 branch target, 2 jal target, 3 GPR[rs].
- alu_op  out  2  0 add, 1 sub, 2 or, 3 lui (imm<<16).
- alu_src_b  out  2  0 GPR[rt], 1 zero-ext imm16, 2 sign-ext imm16.
- reg_we  out  1  GPR write enable.
- reg_dst  out  2  0 rd, 1 rt, 2 $31.
- wd_sel  out  2  0 ALU result register, 1 memory data register, 2 current PC.
- mem_re / mem_we  out  1 / 1  data memory read / write request.
- mdr_we  out  1  capture memory read data.
- retire  out  1  one-cycle pulse in the final cycle of each instruction.
- retired_count  out  32  retired instruction counter.

## Operation
- Registered state: state, cmd_q (5 b, latched command), retired_count. All strobes and selects are decoded combinationally from state, cmd_q and alu_zero / mem_ready. Unlisted outputs are 0 in every state.
- Async reset: state=IDLE, cmd_q=0, retired_count=0. In IDLE all outputs are 0 except state=0.
- IDLE: go to FETCH unconditionally.
- FETCH: ir_we=1, pc_we=1, pc_src=0. Go to DECODE.
- DECODE: latch cmd_q<=command, with codes ≥10 mapped to 0. For nop, assert retire and go to FETCH; otherwise go to EXEC.
- EXEC by cmd_q:
  - add / sub: alu_op 0 / 1, alu_src_b=0; go to WB.
  - ori: alu_op=2, alu_src_b=1; go to WB.
  - lui: alu_op=3, alu_src_b=1; go to WB.
  - lw / sw: alu_op=0, alu_src_b=2; go to MEM.
  - beq: alu_op=1, alu_src_b=0, pc_src=1, pc_we=alu_zero; retire; go to FETCH.
  - jal: pc_src=2, pc_we=1, reg_we=1, reg_dst=2, wd_sel=2; retire; go to FETCH. The register write uses the pre-edge PC, which is already pc+4.
  - jr: pc_src=3, pc_we=1; retire; go to FETCH.
- MEM:
  - mem_re=1 for lw; mem_we=1 for sw. The request is held every cycle until mem_ready=1.
  - On mem_ready=1 for lw: mdr_we=1, go to WB.
  - On mem_ready=1 for sw: retire, go to FETCH.
  - While mem_ready=0: stay in MEM.
- WB:
  - reg_we=1 in all cases.
  - add / sub: reg_dst=0, wd_sel=0.
  - ori / lui: reg_dst=1, wd_sel=0.
  - lw: reg_dst=1, wd_sel=1.
  - Then retire, go to FETCH.
- retired_count increments on every edge where retire=1 and wraps 0xFFFFFFFF→0.

## Timing
- Cycles per instruction (mem_ready=1 immediately): nop 2; beq / jal / jr 3; add / sub / ori / lui 4; sw 4; lw 5. Each wait cycle adds 1 to lw or sw.
- The first FETCH is the second cycle after reset_n deasserts.
- command is sampled only on the DECODE edge. Changes in any other state are ignored.
- alu_zero matters only in EXEC with cmd_q=6. mem_ready matters only in MEM.
- Reset asserted mid-instruction, including during a MEM wait: all strobes drop immediately (asynchronously), state goes to IDLE, the partial instruction does not retire and is not counted.
- retire and the PC / GPR writes of the final state share the same cycle.

## Test plan
- Reset, then add (command=1), mem_ready=1 → states 0,1,2,3,5,1. In WB: reg_we=1, reg_dst=0, wd_sel=0. retired_count=1 after the WB edge.
- lw with mem_ready held low for 3 MEM cycles, then high → mem_re=1 on all 4 MEM cycles, mdr_we=1 only on the last. WB uses reg_dst=1, wd_sel=1. 8 cycles from FETCH to the next FETCH.
- beq with alu_zero=0, then beq with alu_zero=1 → pc_we=0 vs pc_we=1 (pc_src=1) in EXEC. Both retire; count +2.
- jal, then jr → jal EXEC: pc_src=2, reg_we=1, reg_dst=2, wd_sel=2. jr EXEC: pc_src=3, pc_we=1, reg_we=0.
- command=0 and command=17 → 2-cycle nop each, retire in DECODE, no writes except the FETCH ir_we/pc_we.
- sw stalled in MEM, reset_n pulsed low → outputs 0 asynchronously, state=IDLE, retired_count=0. Preload the counter to 0xFFFFFFFF via 2^32 retires or force; the next retire wraps it to 0.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB from the decoder
// command code, drives datapath strobes and selects, and counts retired instructions.
module mc_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  command,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic [2:0]  state,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_op,
    output logic [1:0]  alu_src_b,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic        mem_re,
    output logic        mem_we,
    output logic        mdr_we,
    output logic        retire,
    output logic [31:0] retired_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [4:0] C_NOP = 5'd0;
    localparam logic [4:0] C_ADD = 5'd1;
    localparam logic [4:0] C_SUB = 5'd2;
    localparam logic [4:0] C_ORI = 5'd3;
    localparam logic [4:0] C_LW  = 5'd4;
    localparam logic [4:0] C_SW  = 5'd5;
    localparam logic [4:0] C_BEQ = 5'd6;
    localparam logic [4:0] C_JAL = 5'd7;
    localparam logic [4:0] C_JR  = 5'd8;
    localparam logic [4:0] C_LUI = 5'd9;

    state_t     st;
    logic [4:0] cmd_q;
    logic [4:0] cmd_norm;

    // Undefined decoder codes behave as nop.
    assign cmd_norm = (command >= 5'd10) ? C_NOP : command;
    assign state    = st;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st            <= S_IDLE;
            cmd_q         <= C_NOP;
            retired_count <= 32'd0;
        end else begin
            if (retire)
                retired_count <= retired_count + 32'd1;
            case (st)
                S_IDLE:   st <= S_FETCH;
                S_FETCH:  st <= S_DECODE;
                S_DECODE: begin
                    cmd_q <= cmd_norm;
                    st    <= (cmd_norm == C_NOP) ? S_FETCH : S_EXEC;
                end
                S_EXEC: begin
                    case (cmd_q)
                        C_LW, C_SW:                   st <= S_MEM;
                        C_ADD, C_SUB, C_ORI, C_LUI:   st <= S_WB;
                        default:                      st <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready)
                        st <= (cmd_q == C_LW) ? S_WB : S_FETCH;
                end
                S_WB:     st <= S_FETCH;
                default:  st <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'd0;
        alu_op    = 2'd0;
        alu_src_b = 2'd0;
        reg_we    = 1'b0;
        reg_dst   = 2'd0;
        wd_sel    = 2'd0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mdr_we    = 1'b0;
        retire    = 1'b0;
        case (st)
            S_FETCH: begin
                ir_we = 1'b1;
                pc_we = 1'b1;
            end
            // nop retires here, before cmd_q has been loaded, so look at the live command.
            S_DECODE: retire = (cmd_norm == C_NOP);
            S_EXEC: begin
                case (cmd_q)
                    C_ADD: alu_op = 2'd0;
                    C_SUB: alu_op = 2'd1;
                    C_ORI: begin
                        alu_op    = 2'd2;
                        alu_src_b = 2'd1;
                    end
                    C_LUI: begin
                        alu_op    = 2'd3;
                        alu_src_b = 2'd1;
                    end
                    C_LW, C_SW: alu_src_b = 2'd2;
                    C_BEQ: begin
                        alu_op = 2'd1;
                        pc_src = 2'd1;
                        pc_we  = alu_zero;
                        retire = 1'b1;
                    end
                    C_JAL: begin
                        pc_src  = 2'd2;
                        pc_we   = 1'b1;
                        reg_we  = 1'b1;
                        reg_dst = 2'd2;
                        wd_sel  = 2'd2;
                        retire  = 1'b1;
                    end
                    C_JR: begin
                        pc_src = 2'd3;
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_re = (cmd_q == C_LW);
                mem_we = (cmd_q == C_SW);
                mdr_we = mem_ready && (cmd_q == C_LW);
                retire = mem_ready && (cmd_q == C_SW);
            end
            S_WB: begin
                reg_we = 1'b1;
                retire = 1'b1;
                case (cmd_q)
                    C_LW: begin
                        reg_dst = 2'd1;
                        wd_sel  = 2'd1;
                    end
                    C_ORI, C_LUI: reg_dst = 2'd1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
